painterengine_gpu_fill_source: RTL and testbench



---
 rtl/painterengine_gpu_fill_source.sv | 149 ++++++++++++++
 tb/tb_painterengine_gpu_fill_source.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/painterengine_gpu_fill_source.sv
// Pixel-stream source for one writer lane: arms the writer, generates a solid or
// gradient run of 32-bit pixels through a small FIFO, and reports done/error.
module painterengine_gpu_fill_source #(
  parameter int PARAM_CHANNEL    = 0,
  parameter int PARAM_FIFO_DEPTH = 4
) (
  input  logic         i_wire_clock,
  input  logic         i_wire_reset,
  input  logic         i_wire_start,
  input  logic [31:0]  i_wire_address,
  input  logic [31:0]  i_wire_length,
  input  logic [31:0]  i_wire_color,
  input  logic [31:0]  i_wire_step,
  output logic         o_wire_writer_resetn,
  output logic [3:0]   o_wire_router,
  output logic [127:0] o_wire_address,
  output logic [127:0] o_wire_length,
  output logic [127:0] o_wire_data,
  output logic [3:0]   o_wire_data_valid,
  input  logic [3:0]   i_wire_data_next,
  input  logic         i_wire_writer_done,
  input  logic         i_wire_writer_error,
  output logic         o_wire_busy,
  output logic         o_wire_done,
  output logic         o_wire_error
);
  localparam int AW = $clog2(PARAM_FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(PARAM_FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_WAIT, S_DONE, S_ERROR} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d, len_q, len_d, step_q, step_d, acc_q, acc_d;
  logic [31:0]   gen_q, gen_d, cons_q, cons_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   mem [PARAM_FIFO_DEPTH];
  logic          push, pop;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    step_d   = step_q;
    acc_d    = acc_q;
    gen_d    = gen_q;
    cons_d   = cons_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    pop      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_wire_start) begin
          addr_d   = i_wire_address;
          len_d    = i_wire_length;
          step_d   = i_wire_step;
          acc_d    = i_wire_color;
          gen_d    = '0;
          cons_d   = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
          state_d  = (i_wire_address[1:0] != 2'b00 || i_wire_length == 32'd0) ? S_ERROR : S_ARM;
        end
      end
      S_ARM: state_d = S_RUN;
      S_RUN: begin
        // Error wins over any same-cycle push/pop so cons reflects only accepted words.
        if (i_wire_writer_error) begin
          state_d = S_ERROR;
        end else begin
          push = (gen_q < len_q) && (cnt_q != CNT_FULL);
          pop  = i_wire_data_next[PARAM_CHANNEL] && (cnt_q != '0);
          if (push) begin
            acc_d    = acc_q + step_q;
            gen_d    = gen_q + 32'd1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
          if (pop) begin
            cons_d   = cons_q + 32'd1;
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
          cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
          if (cons_d == len_q) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_wire_writer_error)     state_d = S_ERROR;
        else if (i_wire_writer_done) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      step_q   <= '0;
      acc_q    <= '0;
      gen_q    <= '0;
      cons_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      gen_q    <= gen_d;
      cons_q   <= cons_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge i_wire_clock) begin
    if (push) mem[wr_ptr_q] <= acc_q;
  end

  logic running, armed;
  assign running = (state_q == S_RUN) || (state_q == S_WAIT);
  assign armed   = running || (state_q == S_ARM);

  // Data is gated by occupancy so the bus reads zero after reset or once drained.
  always_comb begin
    o_wire_router     = '0;
    o_wire_address    = '0;
    o_wire_length     = '0;
    o_wire_data       = '0;
    o_wire_data_valid = '0;
    o_wire_router[PARAM_CHANNEL]            = armed;
    o_wire_address[PARAM_CHANNEL*32 +: 32]  = addr_q;
    o_wire_length[PARAM_CHANNEL*32 +: 32]   = len_q;
    o_wire_data[PARAM_CHANNEL*32 +: 32]     = (cnt_q != '0) ? mem[rd_ptr_q] : 32'd0;
    o_wire_data_valid[PARAM_CHANNEL]        = running && (cnt_q != '0);
  end

  assign o_wire_writer_resetn = running;
  assign o_wire_busy          = armed;
  assign o_wire_done          = (state_q == S_DONE);
  assign o_wire_error         = (state_q == S_ERROR);
endmodule

// File: tb/tb_painterengine_gpu_fill_source.sv
// Directed bench for the fill source: job table plus error/reset/ignored-start sequences.
module tb_painterengine_gpu_fill_source;
  logic         clk = 1'b0;
  logic         rst, start, wdone, werr;
  logic [31:0]  addr, len, color, step;
  logic [3:0]   dnext;
  logic         resetn, busy, done, err;
  logic [3:0]   router, dvalid;
  logic [127:0] o_addr, o_len, o_data;

  int checks = 0;
  int failures = 0;

  painterengine_gpu_fill_source #(.PARAM_CHANNEL(0), .PARAM_FIFO_DEPTH(4)) dut (
    .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_start(start),
    .i_wire_address(addr), .i_wire_length(len), .i_wire_color(color), .i_wire_step(step),
    .o_wire_writer_resetn(resetn), .o_wire_router(router),
    .o_wire_address(o_addr), .o_wire_length(o_len), .o_wire_data(o_data),
    .o_wire_data_valid(dvalid), .i_wire_data_next(dnext),
    .i_wire_writer_done(wdone), .i_wire_writer_error(werr),
    .o_wire_busy(busy), .o_wire_done(done), .o_wire_error(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a job; on success return in the cycle where the first pixel is valid (T+3).
  task automatic do_start(input logic [31:0] a, input logic [31:0] l, input logic [31:0] c,
                          input logic [31:0] s, input bit exp_err, input bit ign);
    addr = a; len = l; color = c; step = s; start = 1'b1;
    tick();
    if (exp_err) begin
      start = 1'b0;
      chk("err_flag", err, 1); chk("err_resetn", resetn, 0); chk("err_valid", dvalid, 0);
      chk("err_busy", busy, 0); chk("err_router", router, 0);
      tick();
      chk("err_resetn_hold", resetn, 0); chk("err_hold", err, 1);
      return;
    end
    chk("arm_busy", busy, 1); chk("arm_router", router, 4'b0001); chk("arm_resetn", resetn, 0);
    chk("arm_addr", o_addr, {96'd0, a}); chk("arm_len", o_len, {96'd0, l}); chk("arm_valid", dvalid, 0);
    if (ign) begin
      addr = 32'h0000_2000; len = 32'd99; color = 32'hDEAD_BEEF; step = 32'd7;
    end else start = 1'b0;
    tick();
    start = 1'b0;
    chk("run_resetn", resetn, 1); chk("run_valid0", dvalid, 0); chk("run_addr", o_addr, {96'd0, a});
    tick();
    chk("first_valid", dvalid, 4'b0001); chk("first_data", o_data, {96'd0, c});
  endtask

  // Drain the job, checking every popped word against color + i*step.
  task automatic drain(input logic [31:0] l, input logic [31:0] c, input logic [31:0] s,
                       input bit rnd, input bit ign);
    logic [31:0] expd;
    int k = 0, cyc = 0;
    bit injected = 0;
    expd = c;
    while (k < l && cyc < l * 4 + 50) begin
      start = 1'b0;
      if (ign && k == 2 && !injected) begin
        injected = 1; start = 1'b1; addr = 32'h0000_5000; len = 32'd77;
      end
      dnext = {3'b000, rnd ? 1'($urandom_range(0, 1)) : 1'b1};
      if (dvalid[0] && dnext[0]) begin
        chk("pop_data", o_data, {96'd0, expd});
        expd = expd + s;
        k++;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    dnext = 4'b0;
    chk("pop_count", 128'(k), 128'(l));
  endtask

  task automatic finish_job(input logic [31:0] a);
    chk("wait_valid", dvalid, 0); chk("wait_busy", busy, 1); chk("wait_done", done, 0);
    wdone = 1'b1;
    tick();
    wdone = 1'b0;
    chk("done_flag", done, 1); chk("done_busy", busy, 0); chk("done_resetn", resetn, 0);
    chk("done_router", router, 0); chk("done_addr", o_addr, {96'd0, a});
  endtask

  typedef struct {
    logic [31:0] a, l, c, s;
    bit          exp_err;
  } vec_t;

  initial begin
    vec_t tbl [6];
    tbl[0] = '{32'h0000_1000, 32'd5, 32'h00FF_00FF, 32'd0,         1'b0};
    tbl[1] = '{32'h0000_1002, 32'd5, 32'h00FF_00FF, 32'd0,         1'b1};
    tbl[2] = '{32'h0000_2000, 32'd0, 32'h1234_5678, 32'd1,         1'b1};
    tbl[3] = '{32'h0000_3004, 32'd1, 32'h1234_5678, 32'h1111_1111, 1'b0};
    tbl[4] = '{32'h0000_4000, 32'd9, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0};
    tbl[5] = '{32'h0000_0003, 32'd4, 32'h0000_0001, 32'd1,         1'b1};

    rst = 1'b1; start = 0; wdone = 0; werr = 0; dnext = 0;
    addr = 0; len = 0; color = 0; step = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_resetn", resetn, 0); chk("rst_router", router, 0); chk("rst_addr", o_addr, 0);
    chk("rst_len", o_len, 0); chk("rst_data", o_data, 0); chk("rst_valid", dvalid, 0);
    chk("rst_status", {busy, done, err}, 3'b000);

    for (int i = 0; i < 6; i++) begin
      do_start(tbl[i].a, tbl[i].l, tbl[i].c, tbl[i].s, tbl[i].exp_err, 1'b0);
      if (!tbl[i].exp_err) begin
        drain(tbl[i].l, tbl[i].c, tbl[i].s, 1'b0, 1'b0);
        finish_job(tbl[i].a);
      end
    end

    // Long wrapping gradient with a randomly stalling consumer.
    do_start(32'h0000_8000, 32'd300, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0);
    drain(32'd300, 32'hFFFF_FFFE, 32'd1, 1'b1, 1'b0);
    finish_job(32'h0000_8000);

    // Writer error with a same-cycle pop: the pop must not be counted.
    do_start(32'h0000_9000, 32'd10, 32'h0000_0010, 32'd1, 1'b0, 1'b0);
    dnext = 4'b0001; tick(); tick();
    werr = 1'b1;
    tick();
    werr = 1'b0; dnext = 4'b0;
    chk("merr_flag", err, 1); chk("merr_busy", busy, 0); chk("merr_valid", dvalid, 0);
    chk("merr_resetn", resetn, 0); chk("merr_cons", dut.cons_q, 2);
    do_start(32'h0000_A000, 32'd3, 32'h0000_0100, 32'd2, 1'b0, 1'b0);
    drain(32'd3, 32'h0000_0100, 32'd2, 1'b0, 1'b0);
    finish_job(32'h0000_A000);

    // Reset mid-run with two FIFO entries held.
    do_start(32'h0000_B000, 32'd8, 32'h0000_0055, 32'd1, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_resetn", resetn, 0); chk("mrst_router", router, 0); chk("mrst_addr", o_addr, 0);
    chk("mrst_len", o_len, 0); chk("mrst_data", o_data, 0); chk("mrst_valid", dvalid, 0);
    chk("mrst_status", {busy, done, err}, 3'b000);
    do_start(32'h0000_C000, 32'd4, 32'h0000_0AA0, 32'd5, 1'b0, 1'b0);
    drain(32'd4, 32'h0000_0AA0, 32'd5, 1'b0, 1'b0);
    finish_job(32'h0000_C000);

    // Starts during ARM, RUN and WAIT are ignored.
    do_start(32'h0000_D000, 32'd6, 32'h0000_0300, 32'd3, 1'b0, 1'b1);
    drain(32'd6, 32'h0000_0300, 32'd3, 1'b0, 1'b1);
    addr = 32'h0000_6000; len = 32'd55; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy", busy, 1); chk("ign_addr", o_addr, {96'd0, 32'h0000_D000});
    chk("ign_len", o_len, {96'd0, 32'd6});
    finish_job(32'h0000_D000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
